// File: rtl/ls_unit_if.sv
// ---------------------------------------------------------------------------
// ls_if : bundle of every ls_unit signal except clk/rst.
//
// Port summary
//   req_*          issue-stage request channel (store/load op, address, data, tag)
//   commit_store   ROB retires the oldest uncommitted store
//   flush          squash all uncommitted stores
//   mem_*          single-port data memory (read data valid the cycle after mem_en)
//   ld_*           tagged load result to writeback (one-cycle pulse)
//   sq_full/empty  store-queue status
//
// Modports
//   master : issue stage / ROB / memory side (the testbench drives this side)
//   slave  : ls_unit
//
// Handshake: a request transfers on a posedge where req_valid && req_ready
// are both 1. req_ready may depend combinationally on req_is_store/req_addr
// and flush; the master holds req_* stable until the transfer happens.
// ld_valid is a one-cycle pulse with no back-pressure.
// ---------------------------------------------------------------------------
interface ls_if #(
   parameter int TAG_W = 6
);
   logic             req_valid;
   logic             req_ready;
   logic             req_is_store;
   logic [31:0]      req_addr;
   logic [31:0]      req_data;
   logic [TAG_W-1:0] req_tag;
   logic             commit_store;
   logic             flush;
   logic             mem_en;
   logic             mem_we;
   logic [13:0]      mem_addr;
   logic [31:0]      mem_wdata;
   logic [31:0]      mem_rdata;
   logic             ld_valid;
   logic [31:0]      ld_data;
   logic [TAG_W-1:0] ld_tag;
   logic             sq_full;
   logic             sq_empty;

   modport master (
      output req_valid, req_is_store, req_addr, req_data, req_tag,
             commit_store, flush, mem_rdata,
      input  req_ready, mem_en, mem_we, mem_addr, mem_wdata,
             ld_valid, ld_data, ld_tag, sq_full, sq_empty
   );

   modport slave (
      input  req_valid, req_is_store, req_addr, req_data, req_tag,
             commit_store, flush, mem_rdata,
      output req_ready, mem_en, mem_we, mem_addr, mem_wdata,
             ld_valid, ld_data, ld_tag, sq_full, sq_empty
   );
endinterface

// File: rtl/ls_unit.sv
// ---------------------------------------------------------------------------
// ls_unit : load/store unit in front of the single-port data memory.
//
// Stores wait in an in-order circular store queue (head / commit / tail
// pointers, each with an extra wrap bit). Entries in [head, commit) are
// committed and drain to memory; entries in [commit, tail) are speculative
// and are discarded by flush. Loads go to memory, or are forwarded from the
// youngest matching queue entry, and return one cycle after acceptance.
//
// Ports
//   clk   : clock, all state on posedge
//   rst   : synchronous active-high reset
//   bus   : ls_if.slave (request, commit/flush, memory, load result, status)
//
// Parameters
//   SQ_DEPTH : store-queue entries (power of 2, >= 2)
//   TAG_W    : load destination tag width (must match the interface)
//
// Build option
//   LSU_FWD_EN defined   : store-to-load forwarding from the queue.
//   LSU_FWD_EN undefined : a load matching any queued store is held off
//                          (req_ready=0) until no matching entry remains.
// ---------------------------------------------------------------------------
module ls_unit #(
   parameter int SQ_DEPTH = 4,
   parameter int TAG_W    = 6
) (
   input  logic clk,
   input  logic rst,
   ls_if.slave  bus
);
   localparam int AW = $clog2(SQ_DEPTH);
   typedef logic [AW:0] ptr_t;

   // queue storage; validity is defined purely by the pointers
   logic [13:0] sq_addr [SQ_DEPTH];
   logic [31:0] sq_data [SQ_DEPTH];

   ptr_t head, cmt, tail;
   ptr_t head_next, cmt_next, tail_next;
   ptr_t count;

   logic full, empty, head_cmt, drain_urgent;
   logic [13:0] req_waddr;
   logic [AW-1:0] head_idx, tail_idx, scan_idx, match_idx;
   logic match_any, fwd_hit, ld_block;
   logic st_acc, ld_acc, drain;

   // load response state
   logic             ld_pend_q;
   logic             fwd_q;
   logic [31:0]      fwd_data_q;
   logic [TAG_W-1:0] ld_tag_q;

   // only the word address inside the 64 KiB window is meaningful
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.req_addr[31:16], bus.req_addr[1:0]};

   assign req_waddr = bus.req_addr[15:2];
   assign head_idx  = head[AW-1:0];
   assign tail_idx  = tail[AW-1:0];
   assign count     = tail - head;
   assign full      = (tail_idx == head_idx) && (tail[AW] != head[AW]);
   assign empty     = (tail == head);
   assign head_cmt  = (cmt != head);
   // full queue whose oldest entry may already leave: give the port to the drain
   assign drain_urgent = full && head_cmt;

   // Youngest matching entry: scan oldest to youngest, later hits override.
   // Only entries already in the queue are searched, so a store enqueued
   // in the same cycle is invisible to the load.
   always_comb begin
      match_any = 1'b0;
      match_idx = '0;
      scan_idx  = '0;
      for (int k = 0; k < SQ_DEPTH; k++) begin
         scan_idx = head_idx + AW'(k);
         if ((ptr_t'(k) < count) && (sq_addr[scan_idx] == req_waddr)) begin
            match_any = 1'b1;
            match_idx = scan_idx;
         end
      end
   end

   // handshake, memory port arbitration and pointer next-state
   always_comb begin
`ifdef LSU_FWD_EN
      fwd_hit  = match_any;
      ld_block = 1'b0;
`else
      fwd_hit  = 1'b0;
      ld_block = match_any;
`endif
      bus.req_ready = 1'b0;
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      drain         = 1'b0;

      if (rst || bus.flush) begin
         bus.req_ready = 1'b0;
      end else if (bus.req_is_store) begin
         // no enqueue while full, even if the head drains this cycle
         bus.req_ready = !full;
      end else begin
         bus.req_ready = !drain_urgent && !ld_block;
      end

      st_acc = bus.req_valid && bus.req_ready && bus.req_is_store;
      ld_acc = bus.req_valid && bus.req_ready && !bus.req_is_store;

      // a memory-path load owns the port; otherwise drain the committed head
      if (ld_acc && !fwd_hit) begin
         bus.mem_en   = 1'b1;
         bus.mem_addr = req_waddr;
      end else if (head_cmt && !rst) begin
         bus.mem_we    = 1'b1;
         bus.mem_addr  = sq_addr[head_idx];
         bus.mem_wdata = sq_data[head_idx];
         drain         = 1'b1;
      end

      head_next = head + ptr_t'(drain);
      cmt_next  = (bus.commit_store && (cmt != tail)) ? cmt + ptr_t'(1) : cmt;
      // flush sees the commit pointer after this cycle's commit_store
      tail_next = bus.flush ? cmt_next : tail + ptr_t'(st_acc);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head       <= '0;
         cmt        <= '0;
         tail       <= '0;
         ld_pend_q  <= 1'b0;
         fwd_q      <= 1'b0;
         fwd_data_q <= '0;
         ld_tag_q   <= '0;
      end else begin
         head      <= head_next;
         cmt       <= cmt_next;
         tail      <= tail_next;
         ld_pend_q <= ld_acc;
         if (ld_acc) begin
            fwd_q      <= fwd_hit;
            fwd_data_q <= sq_data[match_idx];
            ld_tag_q   <= bus.req_tag;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (st_acc) begin
         sq_addr[tail_idx] <= req_waddr;
         sq_data[tail_idx] <= bus.req_data;
      end
   end

   // memory read data is passed straight through in the response cycle
   assign bus.ld_valid = ld_pend_q;
   assign bus.ld_data  = !ld_pend_q ? 32'h0 : (fwd_q ? fwd_data_q : bus.mem_rdata);
   assign bus.ld_tag   = ld_pend_q ? ld_tag_q : '0;
   assign bus.sq_full  = full;
   assign bus.sq_empty = empty;
endmodule

// File: doc/ls_unit.md
Name: ls_unit

Overview:
- Load/store unit sitting directly upstream of the data memory in the OoO pipeline.
- Accepts load and store requests from the issue stage.
- Holds stores in an in-order store queue until the ROB commits them, then drains committed stores to memory.
- Issues loads to the single-port data memory, or forwards load data from the store queue, and returns tagged load results to writeback.

Parameters:
- SQ_DEPTH, 4, store-queue entries; power of 2, minimum 2.
- TAG_W, 6, width of the load destination tag (ROB/phys-reg tag).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  issue stage presents a memory op.
- req_ready  out  1  op accepted when req_valid && req_ready.
- req_is_store  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; word address = req_addr[15:2]; other bits ignored.
- req_data  in  32  store data (ignored for loads).
- req_tag  in  TAG_W  load destination tag.
- commit_store  in  1  ROB retires the oldest uncommitted store.
- flush  in  1  squash all uncommitted stores and any load accepted this cycle.
- mem_en  out  1  memory read enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  14  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid the cycle after mem_en.
- ld_valid  out  1  load result valid (one-cycle pulse).
- ld_data  out  32  load result.
- ld_tag  out  TAG_W  load result tag.
- sq_full  out  1  store queue holds SQ_DEPTH entries.
- sq_empty  out  1  store queue empty.

Behaviour:
- Reset: queue emptied; all pointers 0; sq_empty=1, sq_full=0; ld_valid=0, ld_data=0, ld_tag=0; mem_en=0, mem_we=0. Reset mid-operation drops queued stores and the pending load response.
- Store queue:
  - Circular buffer with head, commit and tail pointers, each carrying an extra wrap bit.
  - Entries between head and commit are committed; entries between commit and tail are speculative.
- req_ready:
  - Forced 0 when flush=1.
  - Store: 1 iff count < SQ_DEPTH. No enqueue while full, even if a drain happens the same cycle.
  - Load: 1 unless drain_urgent = (count==SQ_DEPTH && head entry committed).
- commit_store:
  - Advances the commit pointer by one.
  - Ignored when there is no uncommitted entry.
- flush:
  - Applied after any same-cycle commit_store.
  - Sets tail = commit pointer.
- Memory port: one op per cycle, driven combinationally in cycle T.
  - Priority 1, accepted load with no forwarding hit: mem_en=1, mem_we=0, mem_addr = req_addr[15:2].
  - Priority 2, committed head entry present: mem_we=1, mem_en=0, mem_addr/mem_wdata taken from the head entry; head advances at the posedge.
  - Otherwise mem_en=0, mem_we=0.
  - A drain is never blocked by a store enqueue.
- Load latency: 1 cycle on both paths. A load accepted in T gives ld_valid=1 in T+1 with ld_tag = req_tag.
  - Memory path: ld_data = mem_rdata (passed through combinationally in T+1).
  - Forwarding path: search all valid SQ entries (committed and speculative) for a word-address match and select the youngest match. Its data is registered and presented as ld_data in T+1.
  - A store enqueued in cycle T is not visible to a load accepted in the same cycle T.
- Pointer wrap-around: full = (tail index == head index) && (wrap bits differ). Empty = (pointers equal, wrap bits equal).

Optional Feature:
- Macro: LSU_FWD_EN.
- Defined: store-to-load forwarding as described above.
- Undefined: a load whose word address matches any SQ entry is not accepted (req_ready=0) until no matching entry remains. Non-matching loads behave identically in both builds.

Test Plan:
- Reset, then load addr 0x40 with mem word 0x10 = 0xDEADBEEF, tag 5 -> mem_en=1, mem_addr=0x010 in T; ld_valid=1, ld_data=0xDEADBEEF, ld_tag=5 in T+1.
- Store 0x11111111 @0x80, then store 0x22222222 @0x80, then load @0x80 (LSU_FWD_EN) -> ld_data=0x22222222 in T+1, mem_en=0 during the load.
- Enqueue 4 stores, no commit -> sq_full=1; 5th store gets req_ready=0; a load is still accepted; commit_store x4 -> exactly 4 mem_we pulses in order, then sq_empty=1.
- Full queue with committed head plus a load request -> req_ready=0 for the load and the store drains; next cycle the load is accepted.
- 3 stores, commit_store with flush in the same cycle -> 1 entry remains and drains; the other two never write; a load accepted in the flush cycle -> req_ready=0, no ld_valid.
- Assert rst with 2 committed stores queued -> next cycle sq_empty=1, no mem_we, ld_valid=0.
